// File: rtl/imul_req_arbiter.sv
// -----------------------------------------------------------------------------
// imul_req_arbiter
//
// Shares one variable-latency 32x32 multiplier between two requesters. Exactly
// one transaction is in flight at a time: a request is accepted in IDLE,
// issued to the multiplier (ISSUE), the product is awaited (WAIT), and then
// returned to the requester that owns the transaction (RESP).
//
// Configuration macro: IMUL_ARB_RR_EN
//   defined   : round-robin arbitration using a 1-bit last_grant register
//               (reset to 1, so port 0 wins the first contention)
//   undefined : fixed priority, port 0 always wins; no last_grant register
//
// Ports (all handshakes are val/rdy, a transfer happens when both are high):
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req0_* / req1_*      requester operands, msg = {a[63:32], b[31:0]}
//   resp0_* / resp1_*    32-bit product back to the owning requester
//   mul_req_*            64-bit operand request to the shared multiplier
//   mul_resp_*           32-bit product from the shared multiplier
//   busy                 high in every state except IDLE
// -----------------------------------------------------------------------------
module imul_req_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [63:0] req0_msg,

    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [63:0] req1_msg,

    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [31:0] resp0_msg,

    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [31:0] resp1_msg,

    output logic        mul_req_val,
    input  logic        mul_req_rdy,
    output logic [63:0] mul_req_msg,

    input  logic        mul_resp_val,
    output logic        mul_resp_rdy,
    input  logic [31:0] mul_resp_msg,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] latched_msg;  // operands of the in-flight transaction
    logic        owner;        // requester that owns the in-flight transaction
    logic [31:0] prod0;        // last product returned to port 0
    logic [31:0] prod1;        // last product returned to port 1

    logic        grant;        // arbitration winner when a request is present
    logic        accept0;
    logic        accept1;
    logic        prod_fire;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef IMUL_ARB_RR_EN
    logic last_grant;

    // With both ports requesting, the port that did not win last time goes.
    always_comb begin
        if (req0_val && req1_val) begin
            grant = ~last_grant;
        end else begin
            grant = req1_val;
        end
    end

    // last_grant moves only on an accept, so idle cycles do not disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept0) begin
            last_grant <= 1'b0;
        end else if (accept1) begin
            last_grant <= 1'b1;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting.
    assign grant = ~req0_val;
`endif

    assign accept0   = (state == IDLE) && req0_val && !grant;
    assign accept1   = (state == IDLE) && req1_val &&  grant;
    assign prod_fire = (state == WAIT) && mul_resp_val;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;

        case (state)
            IDLE: begin
                req0_rdy = accept0;
                req1_rdy = accept1;
                if (accept0 || accept1) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_req_val = 1'b1;
                if (mul_req_rdy) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                mul_resp_rdy = 1'b1;
                if (mul_resp_val) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp0_val = ~owner;
                resp1_val =  owner;
                if (owner ? resp1_rdy : resp0_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: these data registers are reset on purpose: the message outputs are
    // observable and must read 0 after reset, not leftover operands/products.
    always_ff @(posedge clk) begin
        if (reset) begin
            latched_msg <= 64'd0;
            owner       <= 1'b0;
            prod0       <= 32'd0;
            prod1       <= 32'd0;
        end else begin
            if (accept0) begin
                latched_msg <= req0_msg;
                owner       <= 1'b0;
            end else if (accept1) begin
                latched_msg <= req1_msg;
                owner       <= 1'b1;
            end

            // Each port keeps its own last product so its msg stays stable
            // between transactions that belong to the other port.
            if (prod_fire) begin
                if (owner) begin
                    prod1 <= mul_resp_msg;
                end else begin
                    prod0 <= mul_resp_msg;
                end
            end
        end
    end

    assign mul_req_msg = latched_msg;
    assign resp0_msg   = prod0;
    assign resp1_msg   = prod1;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_imul_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imul_req_arbiter
//
// Directed bench for imul_req_arbiter. Contains a behavioural shared
// multiplier with programmable latency (reset by the same reset) and a
// posedge monitor that logs accepts and response handshakes with their cycle.
// -----------------------------------------------------------------------------
module tb_imul_req_arbiter;

`ifdef IMUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_val = 1'b0, req1_val = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [63:0] req0_msg = 64'd0, req1_msg = 64'd0;
    logic        resp0_val, resp1_val;
    logic        resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic [31:0] resp0_msg, resp1_msg;
    logic        mul_req_val, mul_req_rdy;
    logic [63:0] mul_req_msg;
    logic        mul_resp_val, mul_resp_rdy;
    logic [31:0] mul_resp_msg;
    logic        busy;

    always #5 clk = ~clk;

    imul_req_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .busy         (busy)
    );

    // -------------------------------------------------------------------------
    // Shared multiplier model: product valid mul_lat cycles after accept.
    // -------------------------------------------------------------------------
    int          mul_lat = 4;
    logic        mreq_en = 1'b1;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_op = 64'd0;
    logic [31:0] m_a, m_b;

    assign m_a          = m_op[63:32];
    assign m_b          = m_op[31:0];
    assign mul_req_rdy  = mreq_en & ~m_pend;
    assign mul_resp_val = m_pend && (m_cnt == 0);
    assign mul_resp_msg = m_a * m_b;

    always @(posedge clk) begin
        if (reset) begin
            m_pend <= 1'b0;
            m_cnt  <= 0;
        end else if (mul_req_val && mul_req_rdy) begin
            m_pend <= 1'b1;
            m_op   <= mul_req_msg;
            m_cnt  <= mul_lat - 1;
        end else if (m_pend) begin
            if (mul_resp_val && mul_resp_rdy) begin
                m_pend <= 1'b0;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: cycle counter plus logs of accepts and response handshakes
    // -------------------------------------------------------------------------
    int          cyc = 0;
    int          acc_port[$];
    int          acc_cyc[$];
    int          hs_port[$];
    int          hs_cyc[$];
    logic [31:0] hs_msg[$];
    int          both_rdy = 0;
    int          r1_rdy_seen = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (req0_rdy && req1_rdy) both_rdy = both_rdy + 1;
            if (req1_rdy) r1_rdy_seen = 1;
            if (req0_val && req0_rdy) begin
                acc_port.push_back(0);
                acc_cyc.push_back(cyc);
            end
            if (req1_val && req1_rdy) begin
                acc_port.push_back(1);
                acc_cyc.push_back(cyc);
            end
            if (resp0_val && resp0_rdy) begin
                hs_port.push_back(0);
                hs_cyc.push_back(cyc);
                hs_msg.push_back(resp0_msg);
            end
            if (resp1_val && resp1_rdy) begin
                hs_port.push_back(1);
                hs_cyc.push_back(cyc);
                hs_msg.push_back(resp1_msg);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Checking and helpers
    // -------------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench at a negedge with reset just released and logs cleared.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req0_val  = 1'b0;
        req1_val  = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        mreq_en   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acc_port.delete();
        acc_cyc.delete();
        hs_port.delete();
        hs_cyc.delete();
        hs_msg.delete();
        both_rdy    = 0;
        r1_rdy_seen = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int   t0;
        int   tr;
        logic got;
        logic bad;
        int   exp_port;

        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("rst_req0_rdy",     req0_rdy,     1'b0);
        check("rst_req1_rdy",     req1_rdy,     1'b0);
        check("rst_resp0_val",    resp0_val,    1'b0);
        check("rst_resp1_val",    resp1_val,    1'b0);
        check("rst_resp0_msg",    resp0_msg,    32'd0);
        check("rst_resp1_msg",    resp1_msg,    32'd0);
        check("rst_mul_req_val",  mul_req_val,  1'b0);
        check("rst_mul_req_msg",  mul_req_msg,  64'd0);
        check("rst_mul_resp_rdy", mul_resp_rdy, 1'b0);
        check("rst_busy",         busy,         1'b0);

        // ---------------- single request, k=4 ----------------
        mul_lat  = 4;
        req0_msg = {32'd3, 32'd5};
        req0_val = 1'b1;
        #1;
        check("single_req0_rdy", req0_rdy, 1'b1);
        check("single_req1_rdy", req1_rdy, 1'b0);
        t0 = cyc;
        @(negedge clk);
        req0_val = 1'b0;
        #1;
        check("single_mul_req_val", mul_req_val, 1'b1);
        check("single_mul_req_msg", mul_req_msg, 64'h00000003_00000005);
        check("single_busy",        busy,        1'b1);
        got = 1'b0;
        bad = 1'b0;
        tr  = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (resp1_val) bad = 1'b1;
            if (resp0_val) begin
                got = 1'b1;
                tr  = cyc;
            end
        end
        check("single_timeout",   got,        1'b1);
        check("single_latency",   tr - t0,    6);
        check("single_resp0_msg", resp0_msg,  32'd15);
        check("single_resp1_val", bad,        1'b0);
        @(negedge clk);
        #1;
        check("single_idle_busy", busy, 1'b0);

        // ---------------- contention, four transactions ----------------
        do_reset();
        mul_lat  = 2;
        req0_msg = {32'd2, 32'd10};
        req1_msg = {32'd3, 32'd10};
        req0_val = 1'b1;
        req1_val = 1'b1;
        for (int i = 0; i < 200 && acc_port.size() < 4; i++) @(negedge clk);
        req0_val = 1'b0;
        req1_val = 1'b0;
        check("cont_accepts", acc_port.size(), 4);
        for (int i = 0; i < 100 && hs_port.size() < 4; i++) @(negedge clk);
        check("cont_handshakes", hs_port.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_port = RR ? (i % 2) : 0;
            check($sformatf("cont_grant%0d", i),
                  (i < acc_port.size()) ? acc_port[i] : 99, exp_port);
            check($sformatf("cont_resp_port%0d", i),
                  (i < hs_port.size()) ? hs_port[i] : 99, exp_port);
            check($sformatf("cont_resp_msg%0d", i),
                  (i < hs_msg.size()) ? hs_msg[i] : 32'hDEAD, (exp_port == 1) ? 30 : 20);
        end
        check("cont_one_rdy",     both_rdy,    0);
        check("cont_req1_rdy_hi", r1_rdy_seen, RR ? 1 : 0);

        // ---------------- backpressure ----------------
        do_reset();
        mul_lat   = 3;
        mreq_en   = 1'b0;
        resp1_rdy = 1'b0;
        req1_msg  = {32'hFFFF_FFFF, 32'd2};
        req1_val  = 1'b1;
        #1;
        check("bp_req1_rdy", req1_rdy, 1'b1);
        check("bp_req0_rdy", req0_rdy, 1'b0);
        @(negedge clk);
        req1_val = 1'b0;
        req0_msg = {32'd1, 32'd1};
        req0_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_issue_val%0d", i), mul_req_val, 1'b1);
            check($sformatf("bp_issue_msg%0d", i), mul_req_msg, 64'hFFFFFFFF_00000002);
            check($sformatf("bp_issue_rdy%0d", i), req0_rdy,    1'b0);
            @(negedge clk);
        end
        mreq_en = 1'b1;
        got = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (req0_rdy) bad = 1'b1;
            if (resp1_val) got = 1'b1;
        end
        check("bp_timeout",  got, 1'b1);
        check("bp_wait_rdy", bad, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("bp_resp_val%0d", i),  resp1_val, 1'b1);
            check($sformatf("bp_resp_msg%0d", i),  resp1_msg, 32'hFFFF_FFFE);
            check($sformatf("bp_resp0_val%0d", i), resp0_val, 1'b0);
            check($sformatf("bp_resp_rdy%0d", i),  req0_rdy,  1'b0);
        end
        @(negedge clk);
        resp1_rdy = 1'b1;
        req0_val  = 1'b0;
        @(negedge clk);
        #1;
        check("bp_done_busy",     busy,            1'b0);
        check("bp_done_resp_val", resp1_val,       1'b0);
        check("bp_hold_msg",      resp1_msg,       32'hFFFF_FFFE);
        check("bp_accepts",       acc_port.size(), 1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        mul_lat  = 6;
        req0_msg = {32'd9, 32'd9};
        req0_val = 1'b1;
        @(negedge clk);
        req0_val = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (mul_resp_rdy) got = 1'b1;
            else @(negedge clk);
        end
        check("mrst_reach_wait", got, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_busy",         busy,         1'b0);
        check("mrst_req0_rdy",     req0_rdy,     1'b0);
        check("mrst_req1_rdy",     req1_rdy,     1'b0);
        check("mrst_resp0_val",    resp0_val,    1'b0);
        check("mrst_resp1_val",    resp1_val,    1'b0);
        check("mrst_mul_req_val",  mul_req_val,  1'b0);
        check("mrst_mul_resp_rdy", mul_resp_rdy, 1'b0);
        mul_lat  = 2;
        req0_msg = {32'd7, 32'd6};
        req0_val = 1'b1;
        #1;
        check("mrst_accept", req0_rdy, 1'b1);
        @(negedge clk);
        req0_val = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (resp0_val) got = 1'b1;
        end
        check("mrst_timeout", got,       1'b1);
        check("mrst_product", resp0_msg, 32'd42);

        // ---------------- back-to-back on port 1 ----------------
        do_reset();
        mul_lat  = 1;
        req1_msg = {32'd4, 32'd5};
        req1_val = 1'b1;
        for (int i = 0; i < 100 && acc_port.size() < 3; i++) @(negedge clk);
        req1_val = 1'b0;
        check("b2b_accepts", acc_port.size(), 3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("b2b_gap%0d", i),
                  (acc_cyc.size() > i + 1 && hs_cyc.size() > i) ? acc_cyc[i+1] - hs_cyc[i] : 99, 1);
        end
        check("b2b_turnaround",
              (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : 99, 4);
        check("b2b_msg",  (hs_msg.size()  > 0) ? hs_msg[0]  : 32'hDEAD, 32'd20);
        check("b2b_port", (hs_port.size() > 0) ? hs_port[0] : 99, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
